dm_responder: RTL and testbench
===============================

Name: dm_responder

Overview:
- Data-memory responder for the multicycle MIPS core. It is the slave side of the core's load/store interface.
- Accepts word and byte read/write requests over a req/ready handshake. Each access takes a programmable number of wait states, which models slow memory.
- Holds a 1 KB word-organised array and performs byte stores internally as read-modify-write.
- Replaces the zero-latency data memory when the controller is run in handshake mode.

Parameters:
- ADDR_W, 10, byte-address width; the array holds 2^(ADDR_W-2) 32-bit words.
- WAIT_CYCLES, 2, wait states inserted between request capture and response (0..15).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-low reset; sampled on the rising edge of clk.
- req, input, 1, initiator requests an access.
- we, input, 1, 1 = store, 0 = load.
- byte_sel, input, 1, 1 = byte access (sb/lb), 0 = word access (sw/lw).
- addr, input, ADDR_W, byte address.
- wdata, input, 32, store data; for a byte store only wdata[7:0] is used.
- rdata, output, 32, load data; valid only while ready=1.
- ready, output, 1, one-cycle completion pulse.
- err, output, 1, misaligned-word flag; valid only while ready=1.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state goes to IDLE; ready, err and rdata go to 0; the wait counter goes to 0.
  - Array contents are not cleared.
  - Reset during WAIT aborts the access; a store that has not yet committed is dropped.
- States are IDLE, WAIT and RESP.
- IDLE:
  - On an edge with req=1, capture addr, we, byte_sel and wdata into internal registers.
  - Go to WAIT with counter=WAIT_CYCLES-1, or go directly to RESP if WAIT_CYCLES=0.
- WAIT:
  - Decrement the counter each cycle; on the edge where counter=0, go to RESP.
  - Inputs are ignored in WAIT; deasserting req does not cancel the captured access.
- Entering RESP (same edge):
  - Perform the access using the captured fields.
  - Register ready=1 for exactly one cycle.
- RESP to IDLE is unconditional.
- Latency: ready goes high WAIT_CYCLES+1 cycles after the edge that captured req.
- Back-to-back: if req is held high, the next capture happens in IDLE, so accesses are spaced WAIT_CYCLES+2 cycles apart.
- Word index is addr[ADDR_W-1:2]. Byte lane is addr[1:0], little-endian: lane 0 = bits 7:0, lane 3 = bits 31:24.
- Word load: rdata = mem[index].
- Byte load: rdata = {24'b0, selected byte}. The core performs sign extension.
- Word store: mem[index] = wdata; rdata = 0 during the response.
- Byte store:
  - Replace only the selected lane with wdata[7:0]; the other three lanes are unchanged.
  - The write is a single-edge read-modify-write of the captured word.
- Misaligned word access (byte_sel=0 and addr[1:0]≠0):
  - err=1 together with ready.
  - No write occurs; rdata=0.
- err is always 0 for byte accesses.
- ready, err and rdata are 0 in IDLE and WAIT.
- Addresses wrap within ADDR_W bits; no out-of-range error exists.

Test Plan:
- Reset then word store/load: sw addr=0x010 wdata=0xDEADBEEF, then lw addr=0x010 → ready is high exactly 3 cycles after capture (WAIT_CYCLES=2) and rdata=0xDEADBEEF, err=0.
- Byte merge:
  - Preload word 0x11223344 at 0x020, then sb addr=0x022 wdata=0x000000AA.
  - lw 0x020 → 0x11AA3344.
  - lb 0x023 → 0x00000011.
- Misaligned access: lw addr=0x021 → ready=1, err=1, rdata=0. sw addr=0x026 wdata=0xFFFFFFFF → err=1, and a following lw 0x024 returns the prior value unchanged.
- Handshake robustness:
  - Drop req in the cycle after capture → the access still completes with a single ready pulse.
  - Hold req high across 3 loads → ready pulses spaced 4 cycles apart.
- Reset mid-operation: issue sw 0x030 = 0x12345678, assert rst=0 in the first WAIT cycle → ready never rises; a later lw 0x030 returns the pre-store value.
- Zero wait states: rebuild with WAIT_CYCLES=0 → ready is high 1 cycle after capture, and back-to-back accesses are spaced 2 cycles apart.

Source files
------------

// File: rtl/dm_responder.sv
// dm_responder: data-memory slave for the multicycle MIPS core.
// Serves word and byte loads and stores from a 2^(ADDR_W-2) x 32-bit array.
// Each access waits a fixed number of wait states before it completes.
//
// Handshake: the initiator raises req with we/byte_sel/addr/wdata valid.
// In IDLE the responder captures those fields on the clock edge where req=1.
// After that it ignores its inputs until the access completes. Completion is
// a one-cycle ready pulse. rdata and err are only meaningful while ready=1.
//
// Ports:
//   clk      - rising-edge clock
//   rst      - synchronous active-low reset
//   req      - access request
//   we       - 1 = store, 0 = load
//   byte_sel - 1 = byte access, 0 = word access
//   addr     - byte address (wraps within ADDR_W bits)
//   wdata    - store data (byte stores use wdata[7:0])
//   rdata    - load data, zero outside the response cycle
//   ready    - one-cycle completion pulse
//   err      - misaligned word access flag, valid with ready
//   state_o  - current FSM state (0 = IDLE, 1 = WAIT, 2 = RESP)
module dm_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic              byte_sel,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic              err,
  output logic [1:0]        state_o
);

  localparam int WORDS = 2 ** (ADDR_W - 2);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q;
  logic [3:0]          cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic                bs_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q;
  logic                ready_q;
  logic                err_q;
  logic [31:0]         mem_q [WORDS];

  // Access datapath, evaluated on the edge that enters RESP
  logic                use_inputs;
  logic [ADDR_W-1:0]   acc_addr;
  logic                acc_we;
  logic                acc_bs;
  logic [31:0]         acc_wdata;
  logic [ADDR_W-3:0]   idx;
  logic [1:0]          lane;
  logic [31:0]         cur_word;
  logic [31:0]         merged;
  logic                misaligned;
  logic                go_resp;
  logic                wr_en;
  logic [31:0]         wr_word;
  logic [31:0]         rdata_d;
  logic                err_d;

  always_comb begin
    // With zero wait states the access happens on the capture edge itself,
    // so the fields come straight from the inputs instead of the capture regs.
    use_inputs = (state_q == IDLE);
    acc_addr   = use_inputs ? addr     : addr_q;
    acc_we     = use_inputs ? we       : we_q;
    acc_bs     = use_inputs ? byte_sel : bs_q;
    acc_wdata  = use_inputs ? wdata    : wdata_q;

    idx        = acc_addr[ADDR_W-1:2];
    lane       = acc_addr[1:0];
    cur_word   = mem_q[idx];
    misaligned = !acc_bs && (lane != 2'd0);

    // Byte store: single-edge read-modify-write of the addressed word
    merged = cur_word;
    merged[{lane, 3'b000} +: 8] = acc_wdata[7:0];

    rdata_d = 32'd0;
    if (!misaligned && !acc_we) begin
      rdata_d = acc_bs ? {24'd0, cur_word[{lane, 3'b000} +: 8]} : cur_word;
    end
    err_d   = misaligned;
    wr_en   = acc_we && !misaligned;
    wr_word = acc_bs ? merged : acc_wdata;

    go_resp = ((state_q == IDLE) && req && (WAIT_CYCLES == 0)) ||
              ((state_q == WAIT) && (cnt_q == 4'd0));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      // Response outputs are single-cycle; they fall back to 0 by default
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
      case (state_q)
        IDLE: begin
          if (req) begin
            addr_q  <= addr;
            we_q    <= we;
            bs_q    <= byte_sel;
            wdata_q <= wdata;
            if (WAIT_CYCLES == 0) begin
              state_q <= RESP;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (go_resp) begin
        ready_q <= 1'b1;
        err_q   <= err_d;
        rdata_q <= rdata_d;
      end
    end
  end

  // Array is never reset; a reset during WAIT suppresses the pending store.
  always_ff @(posedge clk) begin
    if (rst && go_resp && wr_en) begin
      mem_q[idx] <= wr_word;
    end
  end

  assign rdata   = rdata_q;
  assign ready   = ready_q;
  assign err     = err_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_dm_responder.sv
// Testbench for dm_responder. It runs two instances side by side:
// index 0 uses WAIT_CYCLES=2 and index 1 uses WAIT_CYCLES=0.
// A transaction-level model predicts which cycle each response lands in and
// what it carries. The outputs of both instances are compared every cycle.
module tb_dm_responder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b0;

  logic        req_s  [2];
  logic        we_s   [2];
  logic        bs_s   [2];
  logic [9:0]  addr_s [2];
  logic [31:0] wd_s   [2];
  logic [31:0] rd_s   [2];
  logic        rdy_s  [2];
  logic        err_s  [2];
  logic [1:0]  st_s   [2];

  dm_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut_w2 (
    .clk(clk), .rst(rst), .req(req_s[0]), .we(we_s[0]), .byte_sel(bs_s[0]),
    .addr(addr_s[0]), .wdata(wd_s[0]), .rdata(rd_s[0]), .ready(rdy_s[0]),
    .err(err_s[0]), .state_o(st_s[0])
  );

  dm_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst), .req(req_s[1]), .we(we_s[1]), .byte_sel(bs_s[1]),
    .addr(addr_s[1]), .wdata(wd_s[1]), .rdata(rd_s[1]), .ready(rdy_s[1]),
    .err(err_s[1]), .state_o(st_s[1])
  );

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each access is scheduled by edge number: the response edge is capture + W.
  // The earliest edge for the next capture is the response edge + 2.
  int          edge_n        = 0;
  int          pend      [2] = '{0, 0};
  int          resp_edge [2] = '{0, 0};
  int          free_edge [2] = '{0, 0};
  logic        exp_rdy   [2] = '{1'b0, 1'b0};
  logic        mwe       [2];
  logic        mbs       [2];
  logic [9:0]  maddr     [2];
  logic [31:0] mwd       [2];
  logic [31:0] mm        [2][256];
  logic [32:0] exp_q0 [$];
  logic [32:0] exp_q1 [$];

  task automatic model_access(input int k, output logic [32:0] r);
    int idx;
    int lane;
    idx  = int'(maddr[k]) / 4;
    lane = int'(maddr[k]) % 4;
    if (!mbs[k] && lane != 0) begin
      r = {1'b1, 32'h0};
    end else if (mwe[k]) begin
      if (mbs[k])
        mm[k][idx] = (mm[k][idx] & ~(32'hFF << (8 * lane))) | ({24'h0, mwd[k][7:0]} << (8 * lane));
      else
        mm[k][idx] = mwd[k];
      r = 33'h0;
    end else if (mbs[k]) begin
      r = {1'b0, (mm[k][idx] >> (8 * lane)) & 32'hFF};
    end else begin
      r = {1'b0, mm[k][idx]};
    end
  endtask

  always @(posedge clk) begin : model
    logic [32:0] r;
    edge_n++;
    for (int k = 0; k < 2; k++) begin
      exp_rdy[k] = 1'b0;
      if (!rst) begin
        pend[k]      = 0;
        free_edge[k] = edge_n + 1;
      end else begin
        if (pend[k] == 0 && edge_n >= free_edge[k] && req_s[k]) begin
          mwe[k]       = we_s[k];
          mbs[k]       = bs_s[k];
          maddr[k]     = addr_s[k];
          mwd[k]       = wd_s[k];
          pend[k]      = 1;
          resp_edge[k] = edge_n + ((k == 0) ? 2 : 0);
        end
        if (pend[k] == 1 && edge_n == resp_edge[k]) begin
          model_access(k, r);
          exp_rdy[k] = 1'b1;
          if (k == 0) exp_q0.push_back(r);
          else        exp_q1.push_back(r);
          pend[k]      = 0;
          free_edge[k] = edge_n + 2;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  // Every advance of time goes through tick(). tick() checks both instances
  // on the falling edge.
  task automatic tick();
    logic [32:0] e;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ready_i%0d_e%0d", k, edge_n), 64'(rdy_s[k]), 64'(exp_rdy[k]));
      e = 33'h0;
      if (exp_rdy[k]) begin
        if (k == 0 && exp_q0.size() > 0) e = exp_q0.pop_front();
        if (k == 1 && exp_q1.size() > 0) e = exp_q1.pop_front();
      end
      chk($sformatf("err_rdata_i%0d_e%0d", k, edge_n), 64'({err_s[k], rd_s[k]}), 64'(e));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic op(input int k, input logic w, input logic b, input logic [9:0] a,
                    input logic [31:0] d, output logic [31:0] rd, output logic e,
                    output int lat);
    req_s[k] = 1'b1; we_s[k] = w; bs_s[k] = b; addr_s[k] = a; wd_s[k] = d;
    lat = 0;
    do begin
      tick();
      lat++;
      if (lat == 1) begin
        // Drop req and scramble the bus; the captured access must still finish
        req_s[k]  = 1'b0;
        we_s[k]   = 1'($urandom_range(0, 1));
        bs_s[k]   = 1'($urandom_range(0, 1));
        addr_s[k] = 10'($urandom);
        wd_s[k]   = $urandom;
      end
    end while (!rdy_s[k] && lat < 40);
    chk($sformatf("op_done_i%0d", k), 64'(rdy_s[k]), 64'd1);
    rd = rd_s[k];
    e  = err_s[k];
    tick();
  endtask

  task automatic held(input int k, input int gap, input logic [9:0] a);
    int pulses[$];
    int cyc;
    cyc = 0;
    req_s[k] = 1'b1; we_s[k] = 1'b0; bs_s[k] = 1'b0; addr_s[k] = a;
    while (pulses.size() < 3 && cyc < 60) begin
      tick();
      cyc++;
      if (rdy_s[k]) pulses.push_back(cyc);
    end
    req_s[k] = 1'b0;
    chk($sformatf("held_pulses_i%0d", k), 64'(pulses.size()), 64'd3);
    if (pulses.size() == 3) begin
      chk($sformatf("held_first_i%0d", k), 64'(pulses[0]), 64'(gap - 1));
      chk($sformatf("held_gap1_i%0d", k), 64'(pulses[1] - pulses[0]), 64'(gap));
      chk($sformatf("held_gap2_i%0d", k), 64'(pulses[2] - pulses[1]), 64'(gap));
    end
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [31:0] rd;
    logic        e;
    int          lat;
    int          k;
    logic        w;
    logic        b;
    logic [9:0]  a;

    for (int i = 0; i < 2; i++) begin
      req_s[i] = 1'b0; we_s[i] = 1'b0; bs_s[i] = 1'b0; addr_s[i] = '0; wd_s[i] = '0;
    end
    rst = 1'b0;
    tick();
    tick();
    chk("rst_ready", 64'(rdy_s[0]), 64'd0);
    chk("rst_err", 64'(err_s[0]), 64'd0);
    chk("rst_rdata", 64'(rd_s[0]), 64'd0);
    chk("rst_state", 64'(st_s[0]), 64'd0);
    rst = 1'b1;
    tick();

    // Fill both arrays so every later load has a known value
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 256; j++)
        op(i, 1'b1, 1'b0, 10'(j * 4), $urandom, rd, e, lat);

    // Word store then load
    op(0, 1'b1, 1'b0, 10'h010, 32'hDEADBEEF, rd, e, lat);
    chk("sw_err", 64'(e), 64'd0);
    chk("sw_rdata", 64'(rd), 64'd0);
    op(0, 1'b0, 1'b0, 10'h010, 32'h0, rd, e, lat);
    chk("lw_latency", 64'(lat), 64'd3);
    chk("lw_rdata", 64'(rd), 64'hDEADBEEF);
    chk("lw_err", 64'(e), 64'd0);

    // Byte merge
    op(0, 1'b1, 1'b0, 10'h020, 32'h11223344, rd, e, lat);
    op(0, 1'b1, 1'b1, 10'h022, 32'h000000AA, rd, e, lat);
    chk("sb_err", 64'(e), 64'd0);
    op(0, 1'b0, 1'b0, 10'h020, 32'h0, rd, e, lat);
    chk("merge_word", 64'(rd), 64'h11AA3344);
    op(0, 1'b0, 1'b1, 10'h023, 32'h0, rd, e, lat);
    chk("lb_lane3", 64'(rd), 64'h00000011);
    op(0, 1'b0, 1'b1, 10'h020, 32'h0, rd, e, lat);
    chk("lb_lane0", 64'(rd), 64'h00000044);

    // Misaligned word accesses
    op(0, 1'b0, 1'b0, 10'h021, 32'h0, rd, e, lat);
    chk("mis_lw_err", 64'(e), 64'd1);
    chk("mis_lw_rdata", 64'(rd), 64'd0);
    op(0, 1'b1, 1'b0, 10'h024, 32'h55667788, rd, e, lat);
    op(0, 1'b1, 1'b0, 10'h026, 32'hFFFFFFFF, rd, e, lat);
    chk("mis_sw_err", 64'(e), 64'd1);
    op(0, 1'b0, 1'b0, 10'h024, 32'h0, rd, e, lat);
    chk("mis_sw_nowrite", 64'(rd), 64'h55667788);

    // req held high: three loads, 4 cycles apart
    held(0, 4, 10'h020);

    // Reset in the first WAIT cycle drops the store
    op(0, 1'b1, 1'b0, 10'h030, 32'hCAFEF00D, rd, e, lat);
    req_s[0] = 1'b1; we_s[0] = 1'b1; bs_s[0] = 1'b0; addr_s[0] = 10'h030; wd_s[0] = 32'h12345678;
    tick();
    rst = 1'b0;
    req_s[0] = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_no_ready", 64'(rdy_s[0]), 64'd0);
    end
    op(0, 1'b0, 1'b0, 10'h030, 32'h0, rd, e, lat);
    chk("abort_prev_value", 64'(rd), 64'hCAFEF00D);

    // Zero wait states
    op(1, 1'b1, 1'b0, 10'h040, 32'hA5A5A5A5, rd, e, lat);
    chk("w0_sw_latency", 64'(lat), 64'd1);
    op(1, 1'b0, 1'b0, 10'h040, 32'h0, rd, e, lat);
    chk("w0_lw_latency", 64'(lat), 64'd1);
    chk("w0_lw_rdata", 64'(rd), 64'hA5A5A5A5);
    held(1, 2, 10'h040);

    // Randomized traffic on both instances
    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 1);
      w = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      a = 10'($urandom);
      if (!b && $urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      op(k, w, b, a, $urandom, rd, e, lat);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
